// File: rtl/stage_pkg.sv
// Types and constants shared by the stage sequencer and the stage renderer.
package stage_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SRST  = 3'd1,
    S_LOAD  = 3'd2,
    S_RUN   = 3'd3,
    S_PAUSE = 3'd4,
    S_OVER  = 3'd5,
    S_CLEAR = 3'd6
  } scroll_state_t;

  localparam int H_RES = 800;
  localparam int V_RES = 600;
  localparam int MAP_W = 16;
  localparam int CORDW = 16;

endpackage

// File: rtl/frame_tick_gen.sv
// Registered one-cycle frame tick at the first vertical-blank line (sx==0, sy==V_RES).
module frame_tick_gen #(
  parameter int CORDW = 16,
  parameter int V_RES = 600
) (
  input  logic                    i_clk_pix,
  input  logic                    i_rst,
  input  logic signed [CORDW-1:0] i_sx,
  input  logic signed [CORDW-1:0] i_sy,
  output logic                    o_tick
);

  localparam logic signed [CORDW-1:0] LP_VY = CORDW'(V_RES);

  logic w_raw;
  assign w_raw = (i_sx == '0) && (i_sy == LP_VY);

  always_ff @(posedge i_clk_pix) begin
    if (i_rst) o_tick <= 1'b0;
    else       o_tick <= w_raw;
  end

endmodule

// File: rtl/stage_scroll_ctrl.sv
// Stage sequencer: renderer reset/start/load handshake, per-frame map scroll,
// pause, game-over, stage-clear and restart handling.
module stage_scroll_ctrl
  import stage_pkg::*;
#(
  parameter int MAP_W     = stage_pkg::MAP_W,
  parameter int CORDW     = stage_pkg::CORDW,
  parameter int H_RES     = stage_pkg::H_RES,
  parameter int V_RES     = stage_pkg::V_RES,
  parameter int MAP_LEN   = 4000,
  parameter int SPEED_MAX = 8,
  parameter int LOAD_TMO  = 4096,
  parameter int SRST_CYC  = 2
) (
  input  logic                    i_clk_pix,
  input  logic                    i_rst,
  input  logic signed [CORDW-1:0] i_sx,
  input  logic signed [CORDW-1:0] i_sy,
  input  logic                    i_game_start,
  input  logic                    i_pause,
  input  logic                    i_game_over,
  input  logic [3:0]              i_speed,
  input  logic                    i_stage_ready,
  output logic                    o_stage_rst,
  output logic                    o_stage_start,
  output logic [MAP_W-1:0]        o_map_x,
  output logic                    o_frame_tick,
  output logic [2:0]              o_state,
  output logic                    o_finished,
  output logic                    o_load_err
);

  localparam int SCW = $clog2(SRST_CYC + 1);
  localparam int LCW = $clog2(LOAD_TMO);
  localparam logic [SCW-1:0]   LP_SRST_LAST = SCW'(SRST_CYC - 1);
  localparam logic [LCW-1:0]   LP_TMO_LAST  = LCW'(LOAD_TMO - 1);
  localparam logic [MAP_W:0]   LP_LIM       = (MAP_W+1)'(MAP_LEN - H_RES);
  localparam logic [3:0]       LP_SPMAX     = 4'(SPEED_MAX);

  scroll_state_t    r_state, w_state_nxt;
  logic [MAP_W-1:0] r_map_x, w_map_nxt;
  logic [SCW-1:0]   r_srst_cnt, w_srst_nxt;
  logic [LCW-1:0]   r_load_cnt, w_load_nxt;
  logic             r_load_err, w_err_nxt;
  logic             r_stage_rst, r_stage_start, r_finished, r_start_q;
  logic             w_tick, w_start_rise;
  logic [3:0]       w_step;
  logic [MAP_W:0]   w_sum;

  frame_tick_gen #(.CORDW(CORDW), .V_RES(V_RES)) u_tick (
    .i_clk_pix (i_clk_pix),
    .i_rst     (i_rst),
    .i_sx      (i_sx),
    .i_sy      (i_sy),
    .o_tick    (w_tick)
  );

  // Restart only on a fresh rise, so a held start button cannot loop the stage.
  assign w_start_rise = i_game_start & ~r_start_q;
  assign w_step       = (i_speed > LP_SPMAX) ? LP_SPMAX : i_speed;
  assign w_sum        = {1'b0, r_map_x} + {{(MAP_W-3){1'b0}}, w_step};

  always_ff @(posedge i_clk_pix) begin
    if (i_rst) begin
      r_state       <= S_IDLE;
      r_map_x       <= '0;
      r_srst_cnt    <= '0;
      r_load_cnt    <= '0;
      r_load_err    <= 1'b0;
      r_stage_rst   <= 1'b0;
      r_stage_start <= 1'b0;
      r_finished    <= 1'b0;
      r_start_q     <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_map_x       <= w_map_nxt;
      r_srst_cnt    <= w_srst_nxt;
      r_load_cnt    <= w_load_nxt;
      r_load_err    <= w_err_nxt;
      r_stage_rst   <= (w_state_nxt == S_SRST);
      r_stage_start <= (r_state == S_LOAD) && (r_load_cnt == '0);
      r_finished    <= (w_state_nxt == S_CLEAR);
      r_start_q     <= i_game_start;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_map_nxt   = r_map_x;
    w_srst_nxt  = r_srst_cnt;
    w_load_nxt  = r_load_cnt;
    w_err_nxt   = r_load_err;
    case (r_state)
      S_IDLE: begin
        if (w_start_rise) begin
          w_state_nxt = S_SRST;
          w_srst_nxt  = '0;
        end
      end
      S_SRST: begin
        w_map_nxt  = '0;
        w_err_nxt  = 1'b0;
        w_load_nxt = '0;
        if (r_srst_cnt == LP_SRST_LAST) w_state_nxt = S_LOAD;
        else                            w_srst_nxt  = r_srst_cnt + 1'b1;
      end
      S_LOAD: begin
        if (i_stage_ready) begin
          w_state_nxt = S_RUN;
        end else if (r_load_cnt == LP_TMO_LAST) begin
          w_err_nxt   = 1'b1;
          w_state_nxt = S_IDLE;
        end else begin
          w_load_nxt = r_load_cnt + 1'b1;
        end
      end
      S_RUN: begin
        if (i_game_over) begin
          w_state_nxt = S_OVER;
        end else if (i_pause) begin
          w_state_nxt = S_PAUSE;
        end else if (w_tick) begin
          if (w_sum >= LP_LIM) begin
            w_map_nxt   = LP_LIM[MAP_W-1:0];
            w_state_nxt = S_CLEAR;
          end else begin
            w_map_nxt = w_sum[MAP_W-1:0];
          end
        end
      end
      S_PAUSE: begin
        if (i_game_over)   w_state_nxt = S_OVER;
        else if (!i_pause) w_state_nxt = S_RUN;
      end
      S_OVER, S_CLEAR: begin
        if (w_start_rise) begin
          w_state_nxt = S_SRST;
          w_srst_nxt  = '0;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign o_stage_rst   = r_stage_rst;
  assign o_stage_start = r_stage_start;
  assign o_map_x       = r_map_x;
  assign o_frame_tick  = w_tick;
  assign o_state       = r_state;
  assign o_finished    = r_finished;
  assign o_load_err    = r_load_err;

endmodule
